// File: rtl/toy_rename_map_table.sv
// Speculative rename map table with in-order branch checkpoints and single-cycle mispredict recovery.
// Optional committed-map flush port is built in when TOY_RENAME_MT_FLUSH_EN is defined.
module toy_rename_map_table #(
    parameter  int ARCH_REG_NUM = 32,
    parameter  int PHY_REG_NUM  = 128,
    parameter  int RENAME_WIDTH = 4,
    parameter  int RD_PORTS     = 8,
    parameter  int CKPT_NUM     = 4,
    parameter  int MODE         = 0,
    localparam int ARCH_ID_W    = $clog2(ARCH_REG_NUM),
    localparam int PHY_ID_W     = $clog2(PHY_REG_NUM),
    localparam int CKPT_ID_W    = $clog2(CKPT_NUM),
    localparam int LANE_W       = $clog2(RENAME_WIDTH)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [RENAME_WIDTH-1:0]                  rn_wr_en,
    input  logic [RENAME_WIDTH-1:0][ARCH_ID_W-1:0]   rn_wr_arch_id,
    input  logic [RENAME_WIDTH-1:0][PHY_ID_W-1:0]    rn_wr_phy_id,
    input  logic [RD_PORTS-1:0][ARCH_ID_W-1:0]       rd_arch_id,
    output logic [RD_PORTS-1:0][PHY_ID_W-1:0]        rd_phy_id,
    input  logic                                     ckpt_alloc_en,
    input  logic [LANE_W-1:0]                        ckpt_alloc_lane,
    output logic [CKPT_ID_W-1:0]                     ckpt_alloc_id,
    output logic                                     ckpt_full,
    output logic                                     ckpt_empty,
    input  logic                                     ckpt_release_en,
    input  logic                                     cancel_en,
`ifdef TOY_RENAME_MT_FLUSH_EN
    input  logic                                     flush_en,
    input  logic [ARCH_REG_NUM-1:0][PHY_ID_W-1:0]    flush_map,
`endif
    input  logic [CKPT_ID_W-1:0]                     cancel_ckpt_id
);

    logic [PHY_ID_W-1:0]  map_q    [ARCH_REG_NUM];
    logic [PHY_ID_W-1:0]  map_d    [ARCH_REG_NUM];
    logic [PHY_ID_W-1:0]  wr_map   [ARCH_REG_NUM];
    logic [PHY_ID_W-1:0]  snap_map [ARCH_REG_NUM];
    logic [PHY_ID_W-1:0]  slot_q   [CKPT_NUM][ARCH_REG_NUM];

    logic [CKPT_ID_W-1:0] head_q, head_d;
    logic [CKPT_ID_W-1:0] tail_q, tail_d;
    logic [CKPT_ID_W:0]   cnt_q, cnt_d;
    logic [CKPT_ID_W-1:0] live_cnt;
    logic                 alloc_ok;
    logic                 rel_ok;
    logic                 slot_we;
    logic                 flush_act;

    function automatic logic hardwired(input int idx);
        return (MODE == 0) && (idx == 0);
    endfunction

`ifdef TOY_RENAME_MT_FLUSH_EN
    assign flush_act = flush_en;
`else
    assign flush_act = 1'b0;
`endif

    assign ckpt_alloc_id = tail_q;
    assign ckpt_full     = (cnt_q == (CKPT_ID_W+1)'(CKPT_NUM));
    assign ckpt_empty    = (cnt_q == '0);

    // Reads see only registered state; entry 0 in MODE 0 is a constant, not a flop.
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_phy_id[p] = '0;
            if (!hardwired(int'(rd_arch_id[p])) && (int'(rd_arch_id[p]) < ARCH_REG_NUM))
                rd_phy_id[p] = map_q[rd_arch_id[p]];
        end
    end

    // Lanes are applied in program order so the youngest writer of an arch reg wins;
    // the snapshot stops after the branch lane.
    always_comb begin
        for (int i = 0; i < ARCH_REG_NUM; i++) begin
            wr_map[i]   = map_q[i];
            snap_map[i] = map_q[i];
            for (int l = 0; l < RENAME_WIDTH; l++) begin
                if (rn_wr_en[l] && (rn_wr_arch_id[l] == ARCH_ID_W'(i))) begin
                    wr_map[i] = rn_wr_phy_id[l];
                    if (l <= int'(ckpt_alloc_lane))
                        snap_map[i] = rn_wr_phy_id[l];
                end
            end
            if (hardwired(i)) begin
                wr_map[i]   = '0;
                snap_map[i] = '0;
            end
        end
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        slot_we  = 1'b0;
        live_cnt = cancel_ckpt_id - head_q;
        rel_ok   = ckpt_release_en && !ckpt_empty;
        alloc_ok = ckpt_alloc_en && (!ckpt_full || ckpt_release_en);
        for (int i = 0; i < ARCH_REG_NUM; i++)
            map_d[i] = wr_map[i];

        if (flush_act) begin
`ifdef TOY_RENAME_MT_FLUSH_EN
            for (int i = 0; i < ARCH_REG_NUM; i++)
                map_d[i] = flush_map[i];
`endif
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else if (cancel_en) begin
            // Restoring a checkpoint drops it and everything younger; a same-cycle
            // release still retires the head.
            for (int i = 0; i < ARCH_REG_NUM; i++)
                map_d[i] = slot_q[cancel_ckpt_id][i];
            tail_d = cancel_ckpt_id;
            cnt_d  = {1'b0, live_cnt};
            if (rel_ok) begin
                head_d = head_q + 1'b1;
                cnt_d  = (live_cnt == '0) ? '0 : ({1'b0, live_cnt} - 1'b1);
            end
        end else begin
            slot_we = alloc_ok;
            if (rel_ok)
                head_d = head_q + 1'b1;
            if (alloc_ok)
                tail_d = tail_q + 1'b1;
            cnt_d = cnt_q + {{CKPT_ID_W{1'b0}}, alloc_ok} - {{CKPT_ID_W{1'b0}}, rel_ok};
        end

        for (int i = 0; i < ARCH_REG_NUM; i++)
            if (hardwired(i))
                map_d[i] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REG_NUM; i++)
                if (!hardwired(i))
                    map_q[i] <= PHY_ID_W'(i);
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < ARCH_REG_NUM; i++)
                if (!hardwired(i))
                    map_q[i] <= map_d[i];
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Snapshot storage carries no reset; a slot is only read after it has been allocated.
    always_ff @(posedge clk) begin
        if (!rst && slot_we) begin
            for (int i = 0; i < ARCH_REG_NUM; i++)
                if (!hardwired(i))
                    slot_q[tail_q][i] <= snap_map[i];
        end
    end

endmodule
